// File: rtl/seq_alu.sv
// seq_alu: registered ALU with 16 logic functions, single-cycle arithmetic
// and multi-cycle unsigned multiply/divide behind a start/busy/done handshake.
module seq_alu #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [3:0]       select,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] alu_out,
   output logic             carry_out,
   output logic             compare,
   output logic             zero
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   // MUL: {high partial, low partial/multiplier}; DIV: {remainder, quotient/dividend}
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;   // multiplicand (MUL) or divisor (DIV)
   logic               op_hi;  // select[0]: high half / remainder

   logic [WIDTH-1:0]   res_c;
   logic               cy_c;
   logic [WIDTH:0]     sum_c;
   logic [WIDTH:0]     msum, dshift, ddiff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt;
   logic [WIDTH-1:0]   mul_res, div_res;
   logic               is_multi, last;

   assign is_multi = ~mode & (select[3:2] == 2'b10);
   assign last     = (cnt == CNT_W'(WIDTH - 1));
   assign busy     = (state != IDLE);

   // Single-cycle result and carry for the logic and arithmetic functions
   always_comb begin
      res_c = '0;
      cy_c  = 1'b0;
      sum_c = '0;
      if (mode) begin
         case (select)
            4'h0: res_c = ~in_a;
            4'h1: res_c = ~(in_a | in_b);
            4'h2: res_c = ~in_a & in_b;
            4'h3: res_c = '0;
            4'h4: res_c = ~(in_a & in_b);
            4'h5: res_c = ~in_b;
            4'h6: res_c = in_a ^ in_b;
            4'h7: res_c = in_a & ~in_b;
            4'h8: res_c = ~in_a | in_b;
            4'h9: res_c = ~(in_a ^ in_b);
            4'hA: res_c = in_b;
            4'hB: res_c = in_a & in_b;
            4'hC: res_c = '1;
            4'hD: res_c = in_a | ~in_b;
            4'hE: res_c = in_a | in_b;
            default: res_c = in_a;
         endcase
      end else begin
         case (select)
            4'b0000: res_c = in_a;
            4'b0001: begin
               sum_c = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_in};
               {cy_c, res_c} = sum_c;
            end
            4'b0010: begin
               sum_c = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, carry_in};
               {cy_c, res_c} = sum_c;
            end
            4'b0011: begin
               sum_c = {1'b0, in_a} + {{WIDTH{1'b0}}, 1'b1};
               {cy_c, res_c} = sum_c;
            end
            4'b0100: begin
               // A + all-ones: carry out is set exactly when A != 0
               sum_c = {1'b0, in_a} + {1'b0, {WIDTH{1'b1}}};
               {cy_c, res_c} = sum_c;
            end
            4'b0101: {cy_c, res_c} = {in_a, 1'b0};
            4'b0110: begin
               res_c = {1'b0, in_a[WIDTH-1:1]};
               cy_c  = in_a[0];
            end
            4'b0111: begin
               res_c = {in_a[WIDTH-1], in_a[WIDTH-1:1]};
               cy_c  = in_a[0];
            end
            default: ;
         endcase
      end
   end

   // One shift-add step and one restoring-divide step per cycle
   always_comb begin
      msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_nxt = {msum, acc[WIDTH-1:1]};
      dshift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      ddiff   = dshift - {1'b0, opnd};
      if (ddiff[WIDTH])
         div_nxt = {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_nxt = {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      mul_res = op_hi ? mul_nxt[2*WIDTH-1:WIDTH] : mul_nxt[WIDTH-1:0];
      div_res = op_hi ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: enter MUL/DIV on an accepted multi-cycle start, leave after WIDTH steps
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start && is_multi) state_nxt = select[1] ? DIV : MUL;
         MUL, DIV: if (last) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         acc       <= '0;
         opnd      <= '0;
         op_hi     <= 1'b0;
         done      <= 1'b0;
         alu_out   <= '0;
         carry_out <= 1'b0;
         compare   <= 1'b0;
         zero      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               compare <= (in_a == in_b);
               if (is_multi) begin
                  cnt   <= '0;
                  op_hi <= select[0];
                  acc   <= {{WIDTH{1'b0}}, select[1] ? in_a : in_b};
                  opnd  <= select[1] ? in_b : in_a;
               end else begin
                  alu_out   <= res_c;
                  carry_out <= cy_c;
                  zero      <= (res_c == '0);
                  done      <= 1'b1;
               end
            end
            MUL: begin
               acc <= mul_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  alu_out   <= mul_res;
                  carry_out <= |mul_nxt[2*WIDTH-1:WIDTH];
                  zero      <= (mul_res == '0);
                  done      <= 1'b1;
               end
            end
            DIV: begin
               acc <= div_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  alu_out   <= div_res;
                  carry_out <= (opnd == '0);
                  zero      <= (div_res == '0);
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16).
module tb_seq_alu;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n, start, mode, carry_in;
   logic [3:0]   select;
   logic [W-1:0] in_a, in_b;
   logic         busy, done, carry_out, compare, zero;
   logic [W-1:0] alu_out;

   int total = 0;
   int bad   = 0;
   int n;
   logic done_seen;
   logic [W-1:0] lexp [16];

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .select(select),
      .carry_in(carry_in), .in_a(in_a), .in_b(in_b), .busy(busy), .done(done),
      .alu_out(alu_out), .carry_out(carry_out), .compare(compare), .zero(zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Drive one start at the current negedge; return in cycle k+1
   task automatic op(input logic m, input logic [3:0] s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic ci);
      mode = m; select = s; in_a = a; in_b = b; carry_in = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Launch a multi-cycle op, count busy cycles (bounded), end in the done cycle
   task automatic op_multi(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic hammer);
      op(1'b0, s, a, b, 1'b0);
      n = 0;
      done_seen = 1'b0;
      while (busy && n < 40) begin
         if (hammer) begin
            start = 1'b1; select = 4'b0001; in_a = '0; in_b = '0;
         end
         if (done) done_seen = 1'b1;
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles", n, 16);
      chk("no_done_while_busy", {31'd0, done_seen}, 0);
      chk("done_after_busy", {31'd0, done}, 1);
   endtask

   initial begin
      lexp = '{16'hFF0F, 16'hF00F, 16'h0F00, 16'h0000, 16'hFFFF, 16'hF0FF, 16'h0FF0, 16'h00F0,
               16'hFF0F, 16'hF00F, 16'h0F00, 16'h0000, 16'hFFFF, 16'hF0FF, 16'h0FF0, 16'h00F0};
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; select = '0; carry_in = 1'b0;
      in_a = '0; in_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_alu", {16'd0, alu_out}, 0);
      chk("rst_flags", {28'd0, carry_out, compare, zero, 1'b0}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // add with carry out, result zero
      op(1'b0, 4'b0001, 16'hFFFF, 16'h0001, 1'b0);
      chk("add_done", {31'd0, done}, 1);
      chk("add_alu", {16'd0, alu_out}, 32'h0000);
      chk("add_cy", {31'd0, carry_out}, 1);
      chk("add_zero", {31'd0, zero}, 1);
      chk("add_cmp", {31'd0, compare}, 0);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 0);
      chk("alu_held", {16'd0, alu_out}, 32'h0000);

      op(1'b0, 4'b0010, 16'h0005, 16'h0007, 1'b1);
      chk("sub_alu", {16'd0, alu_out}, 32'hFFFE);
      chk("sub_cy", {31'd0, carry_out}, 0);
      op(1'b0, 4'b0000, 16'h1234, 16'h1234, 1'b1);
      chk("pass_alu", {16'd0, alu_out}, 32'h1234);
      chk("pass_cy", {31'd0, carry_out}, 0);
      chk("pass_cmp", {31'd0, compare}, 1);
      op(1'b0, 4'b0100, 16'h0000, 16'h0000, 1'b0);
      chk("dec0_alu", {16'd0, alu_out}, 32'hFFFF);
      chk("dec0_cy", {31'd0, carry_out}, 0);
      op(1'b0, 4'b0101, 16'h8001, 16'h0000, 1'b0);
      chk("shl_alu", {16'd0, alu_out}, 32'h0002);
      chk("shl_cy", {31'd0, carry_out}, 1);
      op(1'b0, 4'b0111, 16'h8002, 16'h0000, 1'b0);
      chk("asr_alu", {16'd0, alu_out}, 32'hC001);
      chk("asr_cy", {31'd0, carry_out}, 0);
      op(1'b0, 4'b0110, 16'h8003, 16'h0000, 1'b0);
      chk("lsr_alu", {16'd0, alu_out}, 32'h4001);
      chk("lsr_cy", {31'd0, carry_out}, 1);
      op(1'b0, 4'b1100, 16'h1234, 16'h0000, 1'b1);
      chk("rsvd_alu", {16'd0, alu_out}, 32'h0000);
      chk("rsvd_zero", {31'd0, zero}, 1);
      chk("rsvd_done", {31'd0, done}, 1);
      op(1'b0, 4'b0011, 16'hFFFF, 16'h0000, 1'b0);
      chk("inc_alu", {16'd0, alu_out}, 32'h0000);
      chk("inc_cy", {31'd0, carry_out}, 1);

      // logic sweep
      for (int s = 0; s < 16; s++) begin
         op(1'b1, 4'(s), 16'h00F0, 16'h0F00, 1'b1);
         chk($sformatf("logic_%0h", s), {16'd0, alu_out}, {16'd0, lexp[s]});
         chk($sformatf("logic_cy_%0h", s), {31'd0, carry_out}, 0);
      end
      chk("logic_cmp", {31'd0, compare}, 0);

      // multiply / divide
      op_multi(4'b1000, 16'h1234, 16'h5678, 1'b0);
      chk("mul_lo", {16'd0, alu_out}, 32'h0060);
      chk("mul_lo_cy", {31'd0, carry_out}, 1);
      op_multi(4'b1001, 16'h1234, 16'h5678, 1'b0);
      chk("mul_hi", {16'd0, alu_out}, 32'h0626);
      op_multi(4'b1000, 16'h0003, 16'h0005, 1'b0);
      chk("mul_small", {16'd0, alu_out}, 32'h000F);
      chk("mul_small_cy", {31'd0, carry_out}, 0);
      op_multi(4'b1010, 16'h0064, 16'h0007, 1'b0);
      chk("divq", {16'd0, alu_out}, 32'h000E);
      chk("divq_cy", {31'd0, carry_out}, 0);
      op_multi(4'b1011, 16'h0064, 16'h0007, 1'b0);
      chk("divr", {16'd0, alu_out}, 32'h0002);
      chk("divr_cy", {31'd0, carry_out}, 0);
      op_multi(4'b1010, 16'h0064, 16'h0000, 1'b0);
      chk("div0_q", {16'd0, alu_out}, 32'hFFFF);
      chk("div0_q_cy", {31'd0, carry_out}, 1);
      op_multi(4'b1011, 16'h0064, 16'h0000, 1'b0);
      chk("div0_r", {16'd0, alu_out}, 32'h0064);
      chk("div0_r_cy", {31'd0, carry_out}, 1);

      // start hammered during MUL is ignored; start in done cycle is accepted
      op_multi(4'b1000, 16'h1234, 16'h5678, 1'b1);
      chk("hs_mul_lo", {16'd0, alu_out}, 32'h0060);
      op(1'b0, 4'b0011, 16'h0009, 16'h0000, 1'b0);
      chk("hs_inc_done", {31'd0, done}, 1);
      chk("hs_inc_alu", {16'd0, alu_out}, 32'h000A);
      chk("hs_inc_busy", {31'd0, busy}, 0);

      // reset in the middle of a multiply
      op(1'b0, 4'b1000, 16'h1234, 16'h5678, 1'b0);
      repeat (4) @(negedge clk);
      chk("mid_busy_before", {31'd0, busy}, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_alu", {16'd0, alu_out}, 32'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) done_seen = 1'b1;
      end
      chk("mid_rst_no_done", {31'd0, done_seen}, 0);
      op(1'b0, 4'b0011, 16'h0009, 16'h0000, 1'b0);
      chk("post_rst_done", {31'd0, done}, 1);
      chk("post_rst_alu", {16'd0, alu_out}, 32'h000A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the bitty combinational ALU.
- Keeps the 16 logic functions (mode=1) and a reworked arithmetic set (mode=0) with correct carry_out on every op.
- Adds multi-cycle unsigned multiply/divide behind a start/busy/done handshake.
- Sits between the bitty register file and the writeback mux; the control FSM stalls on busy.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, even)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  operation request; accepted only when busy=0
mode  in  1  1=logic, 0=arithmetic
select  in  4  function code
carry_in  in  1  carry/borrow input for add/sub
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse: result valid
alu_out  out  WIDTH  registered result, held until next accepted start
carry_out  out  1  registered carry/flag
compare  out  1  registered (A==B), captured at start
zero  out  1  registered (alu_out==0)

Behaviour:
- Reset (rst_n low, async): state IDLE; busy, done, carry_out, compare, zero = 0; alu_out = 0; counter and partial registers cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, MUL, DIV. All ops except 1000-1011 in mode 0 are single-cycle and stay in IDLE.
- start sampled at rising edge k with busy=0:
  - Single-cycle op: result, carry_out, compare and zero are registered at edge k; done=1 during cycle k+1.
  - Multi-cycle op: operands latched at edge k; busy=1 for WIDTH cycles; result registered and done=1 on the cycle after busy falls (WIDTH+1 cycles after start); return to IDLE.
- start while busy=1 is ignored; inputs are don't-care then. start in the done cycle is accepted (busy=0).
- compare is captured from in_a/in_b at every accepted start.
- Logic mode (carry_out=0):
  - 0 ~A; 1 ~(A|B); 2 ~A&B; 3 all-zeros; 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B
  - 8 ~A|B; 9 ~(A^B); A B; B A&B; C all-ones; D A|~B; E A|B; F A
- Arithmetic mode; sums are computed WIDTH+1 wide and carry_out is bit WIDTH:
  - 0000 A, carry_out 0
  - 0001 A+B+carry_in
  - 0010 A+~B+carry_in (carry_in=1 gives A-B; carry_out=1 means no borrow)
  - 0011 A+1
  - 0100 A-1 (carry_out=1 iff A!=0)
  - 0101 A<<1, carry_out=A[WIDTH-1]
  - 0110 A>>1 logical, carry_out=A[0]
  - 0111 A>>>1 arithmetic, carry_out=A[0]
  - 1000 MUL low half; carry_out = |(high half)
  - 1001 MUL high half; carry_out = |(high half)
  - 1010 DIVU quotient
  - 1011 REMU remainder
  - 1100-1111 reserved: alu_out=0, carry_out=0, single-cycle done
- MUL: shift-add over the WIDTH bits of B into a 2*WIDTH accumulator; one bit per cycle.
- DIV: restoring divide, one quotient bit per cycle.
  - B==0 still takes WIDTH cycles.
  - Quotient = all-ones, remainder = A, carry_out=1.
  - Otherwise carry_out=0.
- All results truncate to WIDTH; no sticky flags.

Test Plan:
- Reset: drive rst_n low mid-MUL (cycle 5 of 16) -> busy=0, done never pulses, alu_out=0; the next start behaves normally.
- Add/sub, WIDTH=16:
  - mode0 sel0001 A=FFFF B=0001 cin=0 -> alu_out=0000, carry_out=1, zero=1, done in cycle k+1.
  - sel0010 A=0005 B=0007 cin=1 -> FFFE, carry_out=0.
- Logic sweep: mode1 A=00F0 B=0F00, all 16 selects -> values per table (e.g. sel6=0FF0, selC=FFFF, sel3=0000), carry_out=0, compare=0.
- MUL: A=1234 B=5678:
  - sel1000 -> busy 16 cycles, done at k+17, alu_out=0060, carry_out=1.
  - sel1001 -> 0626.
- DIV: A=0064 B=0007:
  - sel1010 -> 000E.
  - sel1011 -> 0002, carry_out=0.
  - B=0000 -> quotient FFFF / remainder 0064, carry_out=1.
- Handshake: start pulsed every cycle during MUL -> only the first accepted; start in the done cycle with sel0011 A=0009 -> accepted, next done shows 000A.
